max7219_rx: RTL and testbench
=============================

# max7219_rx

Serial-side receiver for the MAX7219 3-wire interface (CS, CLK, Din), oversampled on the system clock. It captures 16-bit frames from the MAX7219 driver block, decodes address/data, and maintains a shadow copy of the display-controller register file (8 digit rows plus control registers). It serves as the on-chip loopback/monitor for the driver in self-checking designs, and as a synthesizable display-controller model.

## Interface
- SYNC_STAGES, 2, synchronizer depth on CS/CLK/Din (≥2)
- sys_clk  in  1  system clock, all logic on rising edge
- _rst  in  1  asynchronous active-low reset
- CS  in  1  chip select, active low, asynchronous to sys_clk
- CLK  in  1  serial clock, data sampled on its rising edge
- Din  in  1  serial data, MSB first
- frame_valid  out  1  one-cycle pulse: a 16-bit frame was accepted
- frame_err  out  1  one-cycle pulse: CS rose with bit count ≠ 16
- addr  out  4  address field (D11–D8) of the last accepted frame
- data  out  8  data field (D7–D0) of the last accepted frame
- rd_row  in  3  digit row select for readback (0 → digit register 1)
- row_data  out  8  contents of selected digit register, registered
- decode_mode  out  8  register 0x9
- intensity  out  4  register 0xA, bits 3:0
- scan_limit  out  3  register 0xB, bits 2:0
- shutdown_n  out  1  register 0xC bit 0 (0 = shutdown)
- disp_test  out  1  register 0xF bit 0

## Operation
- CS, CLK, Din each pass through SYNC_STAGES flops; CS sync flops reset to 1, CLK and Din to 0. One further register per line gives edge detection.
- States: IDLE (CS high), SHIFT (CS low). IDLE→SHIFT on synchronized CS falling edge; SHIFT→IDLE on CS rising edge.
- CS falling edge: clear 16-bit shift register and 5-bit bit counter.
- In SHIFT, each synchronized CLK rising edge: shift_reg ← {shift_reg[14:0], Din_sync}; bit counter increments and saturates at 17.
- CLK edges in IDLE are ignored.
- CS rising edge with count = 16:
  - addr/data ← shift_reg[11:8]/[7:0]; frame_valid pulses.
  - Write decoded register: 0x1–0x8 → digit[addr-1]; 0x9 decode_mode; 0xA intensity ← data[3:0]; 0xB scan_limit ← data[2:0]; 0xC shutdown_n ← data[0]; 0xF disp_test ← data[0].
  - 0x0, 0xD and 0xE are no-ops but still raise frame_valid. Bits D15–D12 are ignored.
- CS rising edge with count ≠ 16 (including 0 and saturated 17): frame_err pulses; addr, data and all registers are unchanged.
- CS rising edge and CLK rising edge detected in the same cycle: the CS edge wins and the CLK edge is discarded.
- row_data ← digit[rd_row] every cycle.

## Timing
- Reset (async assert): all outputs 0 (frame_valid, frame_err, addr, data, row_data, decode_mode, intensity, scan_limit, shutdown_n, disp_test); all digit registers 0; state IDLE.
- Pin-to-action latency: SYNC_STAGES+1 sys_clk cycles (3 at default) from a pin edge to the shift or latch.
- frame_valid, frame_err and register updates all occur in the same cycle. addr/data and the registers hold their values until the next accepted frame.
- row_data lags rd_row by 1 cycle. It reflects a digit write 1 cycle after the frame_valid cycle.
- Input requirement: CS and CLK levels stable for ≥ SYNC_STAGES+1 sys_clk cycles. Din must be stable for at least that long around each CLK rising edge. Narrower pulses are not guaranteed to be detected.
- Reset mid-frame: the partial frame is discarded with no pulse. If CS is low at reset release, it is treated as a falling edge and a new frame starts from count 0.
- Back-to-back frames: a CS high time of ≥ SYNC_STAGES+1 cycles between frames must yield one pulse per frame.

## Test plan
- Reset, then frame 0x0A05 → frame_valid for 1 cycle, addr=0xA, data=0x05, intensity=5, no frame_err.
- Frames 0x01FF … 0x08FF (digits 1–8), then sweep rd_row 0–7 → row_data=0xFF for each, 1 cycle after rd_row changes.
- Frame 0xFC01 (upper nibble ignored) → shutdown_n=1; frame 0x0F01 → disp_test=1; frame 0x0D55 → frame_valid pulses, all registers unchanged.
- CS low, 15 CLK pulses, CS high → frame_err pulse, addr/data unchanged. Repeat with 17 pulses → frame_err. Repeat with 0 pulses → frame_err.
- Assert _rst after 8 bits of frame 0x0B07 → all outputs 0 immediately; after release, a full 0x0B07 frame → scan_limit=7.
- Drive from the MAX7219 driver (50 MHz) its full init sequence, registers 0x1–0xC and 0xF → registers match the transmitted data, 13 frame_valid pulses, 0 frame_err.

Source files
------------

// File: rtl/max7219_rx.sv
// max7219_rx: oversampled receiver for the MAX7219 3-wire serial link.
// It captures 16-bit frames, decodes address/data and keeps a shadow copy of
// the display-controller register file (8 digit rows plus control registers).
module max7219_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       _rst,
    input  logic       CS,
    input  logic       CLK,
    input  logic       Din,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [3:0] addr,
    output logic [7:0] data,
    input  logic [2:0] rd_row,
    output logic [7:0] row_data,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown_n,
    output logic       disp_test
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_cs_d;
    logic                   r_clk_d;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [15:0]            r_shift;
    logic [4:0]             r_cnt;
    logic [7:0]             r_digit [0:7];

    logic       w_cs_s, w_clk_s, w_din_s;
    logic       w_cs_fall, w_cs_rise, w_clk_rise;
    logic       w_clear, w_shift, w_close;
    logic       w_accept, w_reject;
    logic [3:0] w_addr;
    logic [7:0] w_data;

    // Synchronizer chains; CS idles high so its chain resets to 1, which also
    // turns a CS held low across reset release into a clean falling edge.
    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            r_cs_sync  <= '1;
            r_clk_sync <= '0;
            r_din_sync <= '0;
            r_cs_d     <= 1'b1;
            r_clk_d    <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], CLK};
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], Din};
            r_cs_d     <= w_cs_s;
            r_clk_d    <= w_clk_s;
        end
    end

    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_din_s    = r_din_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_d & ~w_cs_s;
    assign w_cs_rise  = ~r_cs_d & w_cs_s;
    assign w_clk_rise = w_clk_s & ~r_clk_d;

    // FSM state register
    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and frame control; a CS rise in the same cycle as a CLK rise
    // closes the frame and drops that clock edge.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        w_close     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = SHIFT;
                    w_clear     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_close     = 1'b1;
                end else if (w_clk_rise) begin
                    w_shift = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = w_close & (r_cnt == 5'd16);
    assign w_reject = w_close & (r_cnt != 5'd16);
    assign w_addr   = r_shift[11:8];
    assign w_data   = r_shift[7:0];

    // Shift register and bit counter; the counter sticks at 17 so any overrun
    // still reads as a bad length when CS rises.
    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_shift <= {r_shift[14:0], w_din_s};
            if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
        end
    end

    // Frame result pulses and the last accepted address/data
    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            addr        <= '0;
            data        <= '0;
        end else begin
            frame_valid <= w_accept;
            frame_err   <= w_reject;
            if (w_accept) begin
                addr <= w_addr;
                data <= w_data;
            end
        end
    end

    // Register file writes from accepted frames; 0x0, 0xD, 0xE are no-ops
    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            for (int i = 0; i < 8; i++) r_digit[i] <= '0;
            decode_mode <= '0;
            intensity   <= '0;
            scan_limit  <= '0;
            shutdown_n  <= 1'b0;
            disp_test   <= 1'b0;
        end else if (w_accept) begin
            case (w_addr)
                4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8: r_digit[w_addr[2:0] - 3'd1] <= w_data;
                4'h9:    decode_mode <= w_data;
                4'hA:    intensity   <= w_data[3:0];
                4'hB:    scan_limit  <= w_data[2:0];
                4'hC:    shutdown_n  <= w_data[0];
                4'hF:    disp_test   <= w_data[0];
                default: ;
            endcase
        end
    end

    // Registered digit readback
    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) row_data <= '0;
        else       row_data <= r_digit[rd_row];
    end

endmodule

// File: tb/tb_max7219_rx.sv
// tb_max7219_rx: directed stimulus with a scoreboard of expected frame events.
module tb_max7219_rx;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       CS      = 1'b1;
    logic       CLK     = 1'b0;
    logic       Din     = 1'b0;
    logic [2:0] rd_row  = 3'd0;
    logic       frame_valid, frame_err, shutdown_n, disp_test;
    logic [3:0] addr, intensity;
    logic [7:0] data, row_data, decode_mode;
    logic [2:0] scan_limit;

    max7219_rx #(.SYNC_STAGES(2)) dut (
        .sys_clk(sys_clk), ._rst(rst_n), .CS(CS), .CLK(CLK), .Din(Din),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .addr(addr), .data(data), .rd_row(rd_row), .row_data(row_data),
        .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .shutdown_n(shutdown_n), .disp_test(disp_test)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic       valid;
        logic [3:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0;
    int   n_err = 0;

    logic [7:0] m_digit [0:7];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shdn, m_test;
    logic [3:0] m_addr;
    logic [7:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode = 8'h00; m_int = 4'h0; m_scan = 3'h0;
        m_shdn = 1'b0; m_test = 1'b0; m_addr = 4'h0; m_data = 8'h00;
    endtask

    task automatic model_apply(input logic [15:0] v);
        exp_t e;
        m_addr = v[11:8];
        m_data = v[7:0];
        case (m_addr)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                m_digit[m_addr - 4'h1] = m_data;
            4'h9: m_decode = m_data;
            4'hA: m_int    = m_data[3:0];
            4'hB: m_scan   = m_data[2:0];
            4'hC: m_shdn   = m_data[0];
            4'hF: m_test   = m_data[0];
            default: ;
        endcase
        e.valid = 1'b1; e.a = m_addr; e.d = m_data;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic cs_low();
        CS = 1'b0;
        step(6);
    endtask

    task automatic cs_high();
        CS = 1'b1;
        step(8);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        logic [15:0] s;
        s = v;
        for (int i = 0; i < n; i++) begin
            Din = s[15];
            s = {s[14:0], 1'b0};
            step(4);
            CLK = 1'b1;
            step(4);
            CLK = 1'b0;
        end
        step(2);
    endtask

    task automatic send_frame(input logic [15:0] v);
        model_apply(v);
        cs_low();
        send_bits(v, 16);
        cs_high();
    endtask

    task automatic bad_frame(input int n);
        exp_t e;
        e.valid = 1'b0; e.a = m_addr; e.d = m_data;
        sb.push_back(e);
        cs_low();
        send_bits(16'hA5A5, n);
        cs_high();
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_decode"}, decode_mode, m_decode);
        chk({tag, "_intensity"}, intensity, m_int);
        chk({tag, "_scan"}, scan_limit, m_scan);
        chk({tag, "_shdn"}, shutdown_n, m_shdn);
        chk({tag, "_test"}, disp_test, m_test);
        chk({tag, "_addr"}, addr, m_addr);
        chk({tag, "_data"}, data, m_data);
    endtask

    task automatic sweep_rows(input string tag);
        for (int r = 0; r < 8; r++) begin
            rd_row = r[2:0];
            @(posedge sys_clk);
            @(negedge sys_clk);
            chk($sformatf("%s_row%0d", tag, r), row_data, m_digit[r]);
            #1;
        end
    endtask

    // Scoreboard consumer: every pulse must match the oldest expected event
    always @(negedge sys_clk) begin
        if (frame_valid || frame_err) begin
            if (frame_valid) n_valid++;
            if (frame_err)   n_err++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", {frame_valid, frame_err}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_valid", frame_valid, e.valid);
                chk("sb_err", frame_err, !e.valid);
                chk("sb_addr", addr, e.a);
                chk("sb_data", data, e.d);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0;
        model_reset();
        step(3);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_row", row_data, 8'h00);
        check_regs("rst");
        rst_n = 1'b1;
        step(4);

        // Intensity frame
        send_frame(16'h0A05);
        check_regs("f0A05");

        // All digit rows, then readback sweep
        for (int i = 1; i <= 8; i++) send_frame({8'h00 | i[7:0], 8'hFF});
        sweep_rows("digFF");

        // Upper nibble ignored, test mode, no-op address
        send_frame(16'hFC01);
        check_regs("fFC01");
        send_frame(16'h0F01);
        check_regs("f0F01");
        send_frame(16'h0D55);
        check_regs("f0D55");
        sweep_rows("noop");

        // Bad lengths leave addr/data and registers unchanged
        bad_frame(15);
        check_regs("bad15");
        bad_frame(17);
        check_regs("bad17");
        bad_frame(0);
        check_regs("bad0");

        // Reset mid-frame with CS still low at release
        cs_low();
        send_bits(16'h0B07, 8);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("midrst_valid", frame_valid, 1'b0);
        chk("midrst_err", frame_err, 1'b0);
        chk("midrst_row", row_data, 8'h00);
        check_regs("midrst");
        step(3);
        rst_n = 1'b1;
        step(6);
        model_apply(16'h0B07);
        send_bits(16'h0B07, 16);
        cs_high();
        check_regs("after_rst");
        chk("after_rst_scan7", scan_limit, 3'd7);

        // Driver init sequence: registers 0x1-0xC and 0xF
        v0 = n_valid;
        e0 = n_err;
        send_frame(16'h0F00);
        send_frame(16'h0900);
        send_frame(16'h0A0F);
        send_frame(16'h0B07);
        send_frame(16'h0C01);
        for (int i = 1; i <= 8; i++) send_frame({i[7:0], 8'h10 + i[7:0] * 8'h11});
        check_regs("init");
        sweep_rows("init");
        chk("init_valid_count", n_valid - v0, 13);
        chk("init_err_count", n_err - e0, 0);

        step(10);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
